// File: rtl/sub64_pkg.sv
// Shared types and defaults for the digit-serial 64-bit subtractor.
// Optional signed-overflow output is enabled with the SUB64_OVF_EN macro.
package sub64_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH = 64;
  localparam int SUB_DIGIT = 8;

  // Counter width needed to hold digit indices 0..n-1 (never narrower than 1 bit).
  function automatic int count_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sub64_serial_digit.sv
// One DIGIT-wide slice of the subtractor: x - y - bi, with borrow-out.
// Purely combinational; the top instantiates exactly one and iterates over digits.
module sub_digit #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] i_x,
  input  logic [DIGIT-1:0] i_y,
  input  logic             i_bi,
  output logic [DIGIT-1:0] o_diff,
  output logic             o_bo
);

  logic [DIGIT:0] w_full;

  // The extra top bit of the widened difference is exactly the borrow-out.
  assign w_full = {1'b0, i_x} - {1'b0, i_y} - {{DIGIT{1'b0}}, i_bi};
  assign o_diff = w_full[DIGIT-1:0];
  assign o_bo   = w_full[DIGIT];

endmodule

// File: rtl/sub64_serial.sv
// Digit-serial subtractor d = a - b - bin, DIGIT bits per cycle, with valid/ready on both sides.
// Define SUB64_OVF_EN to add the registered signed-overflow output ovf.
module sub64_serial
  import sub64_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH,
  parameter int DIGIT = SUB_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
`ifdef SUB64_OVF_EN
  output logic             ovf,
`endif
  output sub_state_t       dbg_state
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = count_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if ((WIDTH % DIGIT) != 0 || NDIG < 2) begin : g_param_check
    $error("sub64_serial: WIDTH must be a multiple of DIGIT with at least two digits");
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready is high only in IDLE, out_valid only in DONE; the producer/consumer may
  // hold valid/ready as long as they like, and the result stays stable until taken.

  sub_state_t       r_state;
  sub_state_t       w_next_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_d_sr;
  logic             r_borrow;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;

  logic             w_accept;
  logic             w_last;
  logic             w_release;
  logic [DIGIT-1:0] w_diff;
  logic             w_bo;
  logic [WIDTH-1:0] w_d_next;

`ifdef SUB64_OVF_EN
  logic r_a_sign;
  logic r_b_sign;
  logic r_ovf;
`endif

  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .i_x    (r_a_sr[DIGIT-1:0]),
    .i_y    (r_b_sr[DIGIT-1:0]),
    .i_bi   (r_borrow),
    .o_diff (w_diff),
    .o_bo   (w_bo)
  );

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_release = out_valid && out_ready;
  assign w_last    = (r_state == S_RUN) && (r_count == LAST);
  // Digits enter at the top so the first (least significant) one ends up at bit 0.
  assign w_d_next  = {w_diff, r_d_sr[WIDTH-1:DIGIT]};

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_next_state = S_RUN;
      S_RUN:   if (w_last)    w_next_state = S_DONE;
      S_DONE:  if (w_release) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_d_sr   <= '0;
      r_borrow <= 1'b0;
      r_d      <= '0;
      r_bout   <= 1'b0;
`ifdef SUB64_OVF_EN
      r_a_sign <= 1'b0;
      r_b_sign <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_a_sr   <= a;
        r_b_sr   <= b;
        r_borrow <= bin;
        r_count  <= '0;
`ifdef SUB64_OVF_EN
        r_a_sign <= a[WIDTH-1];
        r_b_sign <= b[WIDTH-1];
`endif
      end else if (r_state == S_RUN) begin
        r_a_sr   <= r_a_sr >> DIGIT;
        r_b_sr   <= r_b_sr >> DIGIT;
        r_d_sr   <= w_d_next;
        r_borrow <= w_bo;
        r_count  <= r_count + CW'(1);
        // Output registers change only on completion, so the previous result survives a new run.
        if (w_last) begin
          r_d    <= w_d_next;
          r_bout <= w_bo;
`ifdef SUB64_OVF_EN
          r_ovf  <= (r_a_sign != r_b_sign) && (w_d_next[WIDTH-1] != r_a_sign);
`endif
        end
      end
    end
  end

  assign d         = r_d;
  assign bout      = r_bout;
  assign dbg_state = r_state;
`ifdef SUB64_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_sub64_serial.sv
// Directed and random checks of sub64_serial against hand values and a 65-bit subtraction model.
// Build with SUB64_OVF_EN defined to also check the ovf output.
module tb_sub64_serial;
  import sub64_pkg::*;

  localparam int W    = 64;
  localparam int NDIG = 8;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic         bout;
  logic [W-1:0] d;
  sub_state_t   dbg_state;
`ifdef SUB64_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Expected results in order of acceptance: {ovf, bout, d}.
  logic [W+1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sub64_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
`ifdef SUB64_OVF_EN
    .ovf       (ovf),
`endif
    .dbg_state (dbg_state)
  );

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                      input logic [W-1:0] ed, input logic eb, input logic eo);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check_val("in_ready_wait", W'(in_ready), W'(1));
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back({eo, eb, ed});
  endtask

  task automatic collect(input string tag, input int hold, input logic junk);
    int lat;
    logic [W+1:0] e;
    logic [W-1:0] d_hold;
    lat = 0;
    while (!out_valid && lat < 20) begin
      check_val({tag, "_busy_in_ready"}, W'(in_ready), W'(0));
      @(posedge clk); #1;
      lat++;
    end
    check_val({tag, "_latency"}, W'(lat), W'(NDIG));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check_val({tag, "_d"}, d, e[W-1:0]);
    check_val({tag, "_bout"}, W'(bout), W'(e[W]));
`ifdef SUB64_OVF_EN
    check_val({tag, "_ovf"}, W'(ovf), W'(e[W+1]));
`endif
    d_hold = d;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (junk) begin
        a = ~a; b = ~b; in_valid = 1'b1;
      end
      @(posedge clk); #1;
      check_val({tag, "_hold_valid"}, W'(out_valid), W'(1));
      check_val({tag, "_hold_d"}, d, d_hold);
      check_val({tag, "_hold_in_ready"}, W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_val({tag, "_released_valid"}, W'(out_valid), W'(0));
    check_val({tag, "_released_in_ready"}, W'(in_ready), W'(1));
    check_val({tag, "_d_retained"}, d, e[W-1:0]);
  endtask

  task automatic run_dir(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tbin, input logic [W-1:0] ed, input logic eb,
                         input logic eo, input int hold);
    send(ta, tb, tbin, ed, eb, eo);
    collect(tag, hold, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ra, rb;
    logic         rbin;
    logic [W:0]   full;
    logic         rovf;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", W'(in_ready), W'(1));
    check_val("rst_out_valid", W'(out_valid), W'(0));
    check_val("rst_d", d, '0);
    check_val("rst_bout", W'(bout), W'(0));
    check_val("rst_state", W'(dbg_state), W'(S_IDLE));
`ifdef SUB64_OVF_EN
    check_val("rst_ovf", W'(ovf), W'(0));
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_dir("t1_5m3", 64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 0);
    run_dir("t2_0m1", 64'd0, 64'd1, 1'b0, ONES, 1'b1, 1'b0, 1);
    run_dir("t2_eq_bin", 64'h1234, 64'h1234, 1'b1, ONES, 1'b1, 1'b0, 0);
    run_dir("eq_nobin", 64'h1234, 64'h1234, 1'b0, 64'd0, 1'b0, 1'b0, 0);
    run_dir("zero_ones", 64'd0, ONES, 1'b1, 64'd0, 1'b1, 1'b0, 2);
    run_dir("t3_55mAA", 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0,
            64'hAAAA_AAAA_AAAA_AAAB, 1'b1, 1'b1, 0);
    run_dir("t3_AAm55", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0,
            64'h5555_5555_5555_5555, 1'b0, 1'b1, 0);
    run_dir("t4_minm1", 64'h8000_0000_0000_0000, 64'd1, 1'b0,
            64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 0);

    // Back-pressure for 5 cycles while a new operand pair is offered and must be ignored.
    send(64'h100, 64'h1, 1'b0, 64'hFF, 1'b0, 1'b0);
    collect("t5_bp", 5, 1'b1);
    @(posedge clk); #1;
    check_val("t5_no_accept", W'(dbg_state), W'(S_IDLE));

    // Reset in the middle of a run abandons it.
    send(64'd100, 64'd7, 1'b0, 64'd93, 1'b0, 1'b0);
    void'(exp_q.pop_back());
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_val("t6_out_valid", W'(out_valid), W'(0));
    check_val("t6_d", d, '0);
    check_val("t6_in_ready", W'(in_ready), W'(1));
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    check_val("t6_no_pulse", W'(out_valid), W'(0));
    run_dir("t6_10m4", 64'd10, 64'd4, 1'b0, 64'd6, 1'b0, 1'b0, 0);

    // Random vectors checked against a 65-bit reference subtraction.
    for (int n = 0; n < 1000; n++) begin
      ra   = {$urandom, $urandom};
      rb   = {$urandom, $urandom};
      rbin = 1'($urandom_range(0, 1));
      if (n % 50 == 0) rb = ra;
      full = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      rovf = (ra[W-1] != rb[W-1]) && (full[W-1] != ra[W-1]);
      send(ra, rb, rbin, full[W-1:0], full[W], rovf);
      collect("rand", $urandom_range(0, 3), 1'b0);
    end

    check_val("queue_empty", W'(exp_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
